// File: rtl/add_arbiter_if.sv
// Requester and shared-adder bundle for add_arbiter.
// res_ovf exists only when ADD_ARB_OVF_EN is defined.
interface add_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      res_sum;
  logic                  res_cout;
`ifdef ADD_ARB_OVF_EN
  logic                  res_ovf;
`endif
  logic                  busy;
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic                  add_cin;
  logic [WIDTH-1:0]      add_s;
  logic [WIDTH-1:0]      add_cout;

`ifdef ADD_ARB_OVF_EN
  modport master (
    output req, req_a, req_b, req_cin,
    output add_s, add_cout,
    input  gnt, done, res_sum, res_cout,
    input  res_ovf, busy,
    input  add_a, add_b, add_cin
  );
  modport slave (
    input  req, req_a, req_b, req_cin,
    input  add_s, add_cout,
    output gnt, done, res_sum, res_cout,
    output res_ovf, busy,
    output add_a, add_b, add_cin
  );
`else
  modport master (
    output req, req_a, req_b, req_cin,
    output add_s, add_cout,
    input  gnt, done, res_sum, res_cout,
    input  busy,
    input  add_a, add_b, add_cin
  );
  modport slave (
    input  req, req_a, req_b, req_cin,
    input  add_s, add_cout,
    output gnt, done, res_sum, res_cout,
    output busy,
    output add_a, add_b, add_cin
  );
`endif
endinterface

// File: rtl/add_arbiter.sv
// Round-robin sequencer sharing one ripple-carry adder.
// Optional signed overflow output: define ADD_ARB_OVF_EN.
module add_arbiter #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 32,
  parameter int SETTLE = 1
) (
  input logic          arb_clk,
  input logic          arb_rst_n,
  add_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    S_IDLE,
    S_SETTLE
  } state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic            sel_cin;
  logic            found;

  wire unused_cout = ^bus.add_cout;

  // Search starts just after the last winner and wraps.
  always_comb begin
    win     = ptr;
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    found   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NREQ;
      if (!found && bus.req[idx]) begin
        found   = 1'b1;
        win     = PW'(idx);
        sel_a   = bus.req_a[idx*WIDTH +: WIDTH];
        sel_b   = bus.req_b[idx*WIDTH +: WIDTH];
        sel_cin = bus.req_cin[idx];
      end
    end
  end

  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      ptr          <= PW'(NREQ-1);
      bus.gnt      <= '0;
      bus.done     <= '0;
      bus.busy     <= 1'b0;
      bus.res_sum  <= '0;
      bus.res_cout <= 1'b0;
`ifdef ADD_ARB_OVF_EN
      bus.res_ovf  <= 1'b0;
`endif
      bus.add_a    <= '0;
      bus.add_b    <= '0;
      bus.add_cin  <= 1'b0;
    end else begin
      bus.gnt  <= '0;
      bus.done <= '0;
      unique case (state)
        S_IDLE: begin
          if (found) begin
            bus.add_a   <= sel_a;
            bus.add_b   <= sel_b;
            bus.add_cin <= sel_cin;
            bus.gnt     <= NREQ'(1) << win;
            ptr         <= win;
            cnt         <= 4'(SETTLE-1);
            bus.busy    <= 1'b1;
            state       <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            bus.res_sum  <= bus.add_s;
            bus.res_cout <= bus.add_cout[WIDTH-1];
`ifdef ADD_ARB_OVF_EN
            bus.res_ovf  <= bus.add_cout[WIDTH-1]
                          ^ bus.add_cout[WIDTH-2];
`endif
            bus.done     <= NREQ'(1) << ptr;
            bus.busy     <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_add_arbiter.sv
// Scoreboard bench for add_arbiter: two instances,
// SETTLE=1 (ia) and SETTLE=3 (ib), each with an adder model.
module tb_add_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add_arbiter_if #(.NREQ(4), .WIDTH(32)) ia();
  add_arbiter_if #(.NREQ(4), .WIDTH(32)) ib();

  add_arbiter #(.NREQ(4), .WIDTH(32), .SETTLE(1)) dut_a (
    .arb_clk(clk), .arb_rst_n(rst_n), .bus(ia));
  add_arbiter #(.NREQ(4), .WIDTH(32), .SETTLE(3)) dut_b (
    .arb_clk(clk), .arb_rst_n(rst_n), .bus(ib));

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  function automatic logic [63:0] rca(
    input logic [31:0] a, input logic [31:0] b, input logic cin);
    logic c;
    logic [31:0] s;
    logic [31:0] cv;
    c = cin;
    for (int i = 0; i < 32; i++) begin
      s[i]  = a[i] ^ b[i] ^ c;
      c     = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
      cv[i] = c;
    end
    return {cv, s};
  endfunction

  assign {ia.add_cout, ia.add_s} = rca(ia.add_a, ia.add_b, ia.add_cin);
  assign {ib.add_cout, ib.add_s} = rca(ib.add_a, ib.add_b, ib.add_cin);

  function automatic exp_t mk(
    int i, logic [31:0] a, logic [31:0] b, logic cin);
    exp_t e;
    logic [32:0] t;
    t = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    e.idx  = i[1:0];
    e.sum  = t[31:0];
    e.cout = t[32];
    e.ovf  = (a[31] == b[31]) && (t[31] != a[31]);
    return e;
  endfunction

  task automatic set_a(int i, logic [31:0] a, logic [31:0] b, logic c);
    ia.req_a[i*32 +: 32] = a;
    ia.req_b[i*32 +: 32] = b;
    ia.req_cin[i] = c;
  endtask

  task automatic set_b(int i, logic [31:0] a, logic [31:0] b, logic c);
    ib.req_a[i*32 +: 32] = a;
    ib.req_b[i*32 +: 32] = b;
    ib.req_cin[i] = c;
  endtask

  // Scoreboard: pop one expected result per done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ia.gnt != 0 || ia.done != 0) begin
        checks++;
        if ((ia.gnt & ia.done) != 0 || !$onehot0(ia.gnt)
            || !$onehot0(ia.done)) begin
          errors++;
          $display("FAIL pulse_a gnt=%b done=%b", ia.gnt, ia.done);
        end
      end
      if (ib.gnt != 0 || ib.done != 0) begin
        checks++;
        if ((ib.gnt & ib.done) != 0 || !$onehot0(ib.gnt)
            || !$onehot0(ib.done)) begin
          errors++;
          $display("FAIL pulse_b gnt=%b done=%b", ib.gnt, ib.done);
        end
      end
      if (ia.done != 0) begin
        exp_t e;
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL sb_a unexpected done=%b", ia.done);
        end else begin
          e = qa.pop_front();
          if (ia.done !== (4'b1 << e.idx) || ia.res_sum !== e.sum
              || ia.res_cout !== e.cout
`ifdef ADD_ARB_OVF_EN
              || ia.res_ovf !== e.ovf
`endif
             ) begin
            errors++;
            $display("FAIL sb_a got done=%b sum=%h c=%b exp idx=%0d sum=%h c=%b",
                     ia.done, ia.res_sum, ia.res_cout,
                     e.idx, e.sum, e.cout);
          end
        end
      end
      if (ib.done != 0) begin
        exp_t e;
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL sb_b unexpected done=%b", ib.done);
        end else begin
          e = qb.pop_front();
          if (ib.done !== (4'b1 << e.idx) || ib.res_sum !== e.sum
              || ib.res_cout !== e.cout) begin
            errors++;
            $display("FAIL sb_b got done=%b sum=%h c=%b exp idx=%0d sum=%h c=%b",
                     ib.done, ib.res_sum, ib.res_cout,
                     e.idx, e.sum, e.cout);
          end
        end
      end
    end
  end

  task automatic drain_a();
    for (int k = 0; k < 20; k++) begin
      if (qa.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL drain_a left=%0d exp 0", qa.size());
      qa.delete();
    end
    @(negedge clk);
  endtask

  task automatic drain_b();
    for (int k = 0; k < 30; k++) begin
      if (qb.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (qb.size() != 0) begin
      errors++;
      $display("FAIL drain_b left=%0d exp 0", qb.size());
      qb.delete();
    end
    @(negedge clk);
  endtask

  task automatic grant_one_a(int i, logic [31:0] a, logic [31:0] b, logic c);
    set_a(i, a, b, c);
    qa.push_back(mk(i, a, b, c));
    ia.req = 4'b1 << i;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ia.gnt != 0) break;
    end
    checks++;
    if (ia.gnt !== (4'b1 << i)) begin
      errors++;
      $display("FAIL grant_a got=%b exp=%b", ia.gnt, 4'b1 << i);
    end
    ia.req = '0;
    drain_a();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ia.gnt, ia.done, ia.busy, ia.res_sum, ia.res_cout,
         ia.add_a, ia.add_b, ia.add_cin} !== '0) begin
      errors++;
      $display("FAIL reset_a outputs nonzero gnt=%b done=%b busy=%b sum=%h",
               ia.gnt, ia.done, ia.busy, ia.res_sum);
    end
    checks++;
    if ({ib.gnt, ib.done, ib.busy, ib.res_sum, ib.res_cout,
         ib.add_a, ib.add_b, ib.add_cin} !== '0) begin
      errors++;
      $display("FAIL reset_b outputs nonzero gnt=%b done=%b busy=%b sum=%h",
               ib.gnt, ib.done, ib.busy, ib.res_sum);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ia.gnt !== 4'b0 || ia.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_a gnt=%b busy=%b exp 0", ia.gnt, ia.busy);
    end
  endtask

  task automatic test_single();
    set_a(0, 32'd5, 32'd7, 1'b0);
    qa.push_back(mk(0, 32'd5, 32'd7, 1'b0));
    ia.req = 4'b0001;
    @(negedge clk);
    checks++;
    if (ia.gnt !== 4'b0001 || ia.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_gnt gnt=%b busy=%b exp 0001 1", ia.gnt, ia.busy);
    end
    ia.req = '0;
    @(negedge clk);
    checks++;
    if (ia.done !== 4'b0001 || ia.gnt !== 4'b0
        || ia.res_sum !== 32'd12 || ia.res_cout !== 1'b0) begin
      errors++;
      $display("FAIL single_done done=%b sum=%0d exp 0001 12",
               ia.done, ia.res_sum);
    end
    @(negedge clk);
    checks++;
    if (ia.done !== 4'b0 || ia.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle done=%b busy=%b exp 0", ia.done, ia.busy);
    end
  endtask

  task automatic test_carry();
    grant_one_a(0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    checks++;
    if (ia.res_sum !== 32'd0 || ia.res_cout !== 1'b1) begin
      errors++;
      $display("FAIL carry_wrap sum=%h c=%b exp 0 1",
               ia.res_sum, ia.res_cout);
    end
    grant_one_a(0, 32'h7FFF_FFFF, 32'd1, 1'b0);
    grant_one_a(2, 32'h8000_0000, 32'h8000_0000, 1'b1);
  endtask

  task automatic test_round_robin();
    int order[5];
    int n;
    int last;
    order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      set_a(i, 32'(1000*(i+1)+i), 32'(17*i+3), i[0]);
    for (int i = 0; i < 5; i++) begin
      int j;
      j = order[i];
      qa.push_back(mk(j, 32'(1000*(j+1)+j), 32'(17*j+3), j[0]));
    end
    ia.req = 4'b1111;
    n = 0;
    last = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (ia.gnt != 0) begin
        checks++;
        if (ia.gnt !== (4'b1 << order[n])) begin
          errors++;
          $display("FAIL rr_order n=%0d got=%b exp=%b",
                   n, ia.gnt, 4'b1 << order[n]);
        end
        if (n > 0) begin
          checks++;
          if (cyc - last != 2) begin
            errors++;
            $display("FAIL rr_spacing got=%0d exp 2", cyc - last);
          end
        end
        last = cyc;
        n++;
        if (n == 5) begin
          ia.req = '0;
          break;
        end
      end
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL rr_count got=%0d exp 5", n);
      ia.req = '0;
    end
    drain_a();
  endtask

  task automatic test_settle3();
    int busy_cnt;
    int done_at;
    busy_cnt = 0;
    done_at = -1;
    set_b(0, 32'd100, 32'd23, 1'b1);
    qb.push_back(mk(0, 32'd100, 32'd23, 1'b1));
    ib.req = 4'b0001;
    @(negedge clk);
    checks++;
    if (ib.gnt !== 4'b0001) begin
      errors++;
      $display("FAIL s3_gnt got=%b exp 0001", ib.gnt);
    end
    ib.req = '0;
    set_b(0, 32'd999, 32'd23, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (ib.busy === 1'b1) busy_cnt++;
      if (ib.done != 0 && done_at < 0) done_at = i;
    end
    checks++;
    if (busy_cnt != 3 || done_at != 3) begin
      errors++;
      $display("FAIL s3_timing busy=%0d done_at=%0d exp 3 3",
               busy_cnt, done_at);
    end
    checks++;
    if (ib.res_sum !== 32'd124) begin
      errors++;
      $display("FAIL s3_sum got=%0d exp 124", ib.res_sum);
    end
    drain_b();
  endtask

  task automatic test_withdraw();
    logic saw2;
    logic got;
    saw2 = 1'b0;
    got = 1'b0;
    set_b(1, 32'd40, 32'd2, 1'b0);
    set_b(2, 32'd77, 32'd77, 1'b0);
    set_b(3, 32'hDEAD_0000, 32'h0000_BEEF, 1'b1);
    qb.push_back(mk(1, 32'd40, 32'd2, 1'b0));
    ib.req = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ib.gnt != 0) break;
    end
    checks++;
    if (ib.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL wd_first got=%b exp 0010", ib.gnt);
    end
    ib.req = 4'b0100;
    @(negedge clk);
    ib.req = 4'b1000;
    qb.push_back(mk(3, 32'hDEAD_0000, 32'h0000_BEEF, 1'b1));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ib.gnt[2] || ib.done[2]) saw2 = 1'b1;
      if (ib.gnt != 0) begin
        got = 1'b1;
        checks++;
        if (ib.gnt !== 4'b1000) begin
          errors++;
          $display("FAIL wd_next got=%b exp 1000", ib.gnt);
        end
        ib.req = '0;
        break;
      end
    end
    ib.req = '0;
    checks++;
    if (saw2 !== 1'b0 || got !== 1'b1) begin
      errors++;
      $display("FAIL wd_req2 saw2=%b got=%b exp 0 1", saw2, got);
    end
    drain_b();
  endtask

  task automatic test_reset_mid();
    int n;
    int order[2];
    order = '{0, 1};
    set_a(0, 32'd1, 32'd1, 1'b0);
    ia.req = 4'b0001;
    @(negedge clk);
    ia.req = '0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ia.gnt, ia.done, ia.busy, ia.res_sum, ia.res_cout,
         ia.add_a, ia.add_b, ia.add_cin} !== '0) begin
      errors++;
      $display("FAIL rmid_async gnt=%b busy=%b sum=%h add_a=%h exp 0",
               ia.gnt, ia.busy, ia.res_sum, ia.add_a);
    end
    @(negedge clk);
    checks++;
    if (ia.done !== 4'b0) begin
      errors++;
      $display("FAIL rmid_done got=%b exp 0", ia.done);
    end
    rst_n = 1'b1;
    grant_one_a(1, 32'd300, 32'd45, 1'b0);
    set_a(0, 32'd8, 32'd9, 1'b1);
    set_a(1, 32'd10, 32'd11, 1'b0);
    qa.push_back(mk(0, 32'd8, 32'd9, 1'b1));
    qa.push_back(mk(1, 32'd10, 32'd11, 1'b0));
    ia.req = 4'b0011;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ia.gnt != 0) begin
        checks++;
        if (ia.gnt !== (4'b1 << order[n])) begin
          errors++;
          $display("FAIL rmid_order n=%0d got=%b exp=%b",
                   n, ia.gnt, 4'b1 << order[n]);
        end
        n++;
        if (n == 2) break;
      end
    end
    ia.req = '0;
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL rmid_count got=%0d exp 2", n);
    end
    drain_a();
  endtask

  initial begin
    ia.req = '0;
    ia.req_a = '0;
    ia.req_b = '0;
    ia.req_cin = '0;
    ib.req = '0;
    ib.req_a = '0;
    ib.req_b = '0;
    ib.req_cin = '0;
    test_reset();
    test_single();
    test_carry();
    test_round_robin();
    test_settle3();
    test_withdraw();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL sb_empty qa=%0d qb=%0d exp 0", qa.size(), qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
